wb_arbiter: RTL and testbench

- Writeback arbiter directly upstream of the register file.
- Accepts results from three producers (0 = ALU, 1 = LSU, 2 = NPU) over valid/ready handshakes.
- Buffers each producer in a small FIFO and issues up to two register writes per cycle onto the regfile write ports A and B.
- Emits a per-register clear mask so the regfile scoreboard can retire pending writes.

---
 rtl/wb_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_wb_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges ALU/LSU/NPU results into two regfile write ports.
// Ports: clk, rst (sync, active-high); src_valid/src_ready/src_rd/src_data
//   per producer; write_enable/addr/data on ports A and B; clear_mask.
module wb_arbiter #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2:0]          src_valid,
    output logic [2:0]          src_ready,
    input  logic [3*ADDR_W-1:0] src_rd,
    input  logic [3*DATA_W-1:0] src_data,
    output logic                write_enable_a,
    output logic [ADDR_W-1:0]   write_addr_a,
    output logic [DATA_W-1:0]   write_data_a,
    output logic                write_enable_b,
    output logic [ADDR_W-1:0]   write_addr_b,
    output logic [DATA_W-1:0]   write_data_b,
    output logic [31:0]         clear_mask
);

    localparam int N  = 3;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] rd_mem_q   [N][DEPTH];
    logic [ADDR_W-1:0] rd_mem_d   [N][DEPTH];
    logic [DATA_W-1:0] data_mem_q [N][DEPTH];
    logic [DATA_W-1:0] data_mem_d [N][DEPTH];
    logic [PW-1:0]     head_q [N];
    logic [PW-1:0]     head_d [N];
    logic [PW-1:0]     tail_q [N];
    logic [PW-1:0]     tail_d [N];
    logic [CW-1:0]     count_q [N];
    logic [CW-1:0]     count_d [N];
    logic [1:0]        rr_ptr_q, rr_ptr_d;

    logic              we_a_q, we_a_d, we_b_q, we_b_d;
    logic [ADDR_W-1:0] addr_a_q, addr_a_d, addr_b_q, addr_b_d;
    logic [DATA_W-1:0] data_a_q, data_a_d, data_b_q, data_b_d;
    logic [31:0]       mask_q, mask_d;

    logic [N-1:0]      push, pop, nonempty;
    logic [ADDR_W-1:0] head_rd   [N];
    logic [DATA_W-1:0] head_data [N];
    logic [1:0]        order [N];
    logic              gnt_a, gnt_b;
    logic [1:0]        a_idx, b_idx;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [1:0] wrap3(input logic [2:0] v);
        return (v >= 3'd3) ? 2'(v - 3'd3) : v[1:0];
    endfunction

    // Ready depends only on registered occupancy.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            src_ready[i] = (count_q[i] < CW'(DEPTH));
            nonempty[i]  = (count_q[i] != '0);
            head_rd[i]   = rd_mem_q[i][head_q[i]];
            head_data[i] = data_mem_q[i][head_q[i]];
            // x0 results complete the handshake but are never stored.
            push[i]      = src_valid[i] & src_ready[i]
                         & (src_rd[i*ADDR_W +: ADDR_W] != '0);
        end
    end

    // Round-robin scan; a head matching grant A's rd waits a cycle so the
    // later-scanned producer's value lands last.
    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        a_idx = 2'd0;
        b_idx = 2'd0;
        for (int k = 0; k < N; k++) begin
            order[k] = wrap3({1'b0, rr_ptr_q} + 3'(k));
        end
        for (int k = 0; k < N; k++) begin
            if (nonempty[order[k]]) begin
                if (!gnt_a) begin
                    gnt_a = 1'b1;
                    a_idx = order[k];
                end else if (!gnt_b && (head_rd[order[k]] != head_rd[a_idx])) begin
                    gnt_b = 1'b1;
                    b_idx = order[k];
                end
            end
        end
        pop = '0;
        if (gnt_a) pop[a_idx] = 1'b1;
        if (gnt_b) pop[b_idx] = 1'b1;
        if (gnt_b) begin
            rr_ptr_d = wrap3({1'b0, b_idx} + 3'd1);
        end else if (gnt_a) begin
            rr_ptr_d = wrap3({1'b0, a_idx} + 3'd1);
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    always_comb begin
        rd_mem_d   = rd_mem_q;
        data_mem_d = data_mem_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        for (int i = 0; i < N; i++) begin
            if (push[i]) begin
                rd_mem_d[i][tail_q[i]]   = src_rd[i*ADDR_W +: ADDR_W];
                data_mem_d[i][tail_q[i]] = src_data[i*DATA_W +: DATA_W];
                tail_d[i] = ptr_inc(tail_q[i]);
            end
            if (pop[i]) begin
                head_d[i] = ptr_inc(head_q[i]);
            end
            count_d[i] = count_q[i] + CW'(push[i]) - CW'(pop[i]);
        end
    end

    always_comb begin
        we_a_d   = gnt_a;
        we_b_d   = gnt_b;
        addr_a_d = gnt_a ? head_rd[a_idx]   : '0;
        data_a_d = gnt_a ? head_data[a_idx] : '0;
        addr_b_d = gnt_b ? head_rd[b_idx]   : '0;
        data_b_d = gnt_b ? head_data[b_idx] : '0;
        mask_d   = '0;
        if (gnt_a) mask_d = mask_d | (32'd1 << addr_a_d);
        if (gnt_b) mask_d = mask_d | (32'd1 << addr_b_d);
    end

    // Storage needs no reset; occupancy is tracked by count/pointers.
    always_ff @(posedge clk) begin
        rd_mem_q   <= rd_mem_d;
        data_mem_q <= data_mem_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                head_q[i]  <= '0;
                tail_q[i]  <= '0;
                count_q[i] <= '0;
            end
            rr_ptr_q <= 2'd0;
            we_a_q   <= 1'b0;
            we_b_q   <= 1'b0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            data_a_q <= '0;
            data_b_q <= '0;
            mask_q   <= '0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            rr_ptr_q <= rr_ptr_d;
            we_a_q   <= we_a_d;
            we_b_q   <= we_b_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            data_a_q <= data_a_d;
            data_b_q <= data_b_d;
            mask_q   <= mask_d;
        end
    end

    assign write_enable_a = we_a_q;
    assign write_addr_a   = addr_a_q;
    assign write_data_a   = data_a_q;
    assign write_enable_b = we_b_q;
    assign write_addr_b   = addr_b_q;
    assign write_data_b   = data_b_q;
    assign clear_mask     = mask_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed stimulus with a scoreboard queue and an
// independent monitor that matches every regfile write against it.
module tb_wb_arbiter;

    localparam int DW = 64;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    src_valid;
    logic [2:0]    src_ready;
    logic [3*AW-1:0] src_rd;
    logic [3*DW-1:0] src_data;
    logic          we_a, we_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] data_a, data_b;
    logic [31:0]   clear_mask;

    always #5 clk = ~clk;

    wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .src_valid      (src_valid),
        .src_ready      (src_ready),
        .src_rd         (src_rd),
        .src_data       (src_data),
        .write_enable_a (we_a),
        .write_addr_a   (addr_a),
        .write_data_a   (data_a),
        .write_enable_b (we_b),
        .write_addr_b   (addr_b),
        .write_data_b   (data_b),
        .clear_mask     (clear_mask)
    );

    typedef struct {
        int          src;
        logic [4:0]  rd;
        logic [63:0] data;
    } ent_t;

    ent_t        sb_q[$];
    int          n_err = 0;
    int          n_chk = 0;
    bit          mon_en = 1'b0;
    logic [63:0] regf [32];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Only each producer's oldest outstanding entry may be written next.
    task automatic sb_match(input string nm, input logic [4:0] r,
                            input logic [63:0] d);
        bit seen [3];
        int f;
        f = -1;
        for (int i = 0; i < 3; i++) seen[i] = 1'b0;
        for (int j = 0; j < sb_q.size(); j++) begin
            if (!seen[sb_q[j].src]) begin
                seen[sb_q[j].src] = 1'b1;
                if (sb_q[j].rd == r && sb_q[j].data == d) begin
                    f = j;
                    break;
                end
            end
        end
        n_chk++;
        if (f < 0) begin
            n_err++;
            $display("FAIL %s unexpected write: got rd=%0d data=%h required none",
                     nm, r, d);
        end else begin
            sb_q.delete(f);
        end
    endtask

    always @(negedge clk) begin
        logic [31:0] m;
        if (mon_en) begin
            m = '0;
            if (we_a) begin
                m[addr_a] = 1'b1;
                sb_match("port_a", addr_a, data_a);
                regf[addr_a] = data_a;
            end else begin
                chk("a_idle_zero", {63'd0, (addr_a != 0) || (data_a != 0)}, 64'd0);
            end
            if (we_b) begin
                m[addr_b] = 1'b1;
                chk("b_needs_a", {63'd0, we_a}, 64'd1);
                chk("b_rd_distinct", {63'd0, addr_b != addr_a}, 64'd1);
                sb_match("port_b", addr_b, data_b);
                regf[addr_b] = data_b;
            end else begin
                chk("b_idle_zero", {63'd0, (addr_b != 0) || (data_b != 0)}, 64'd0);
            end
            chk("clear_mask", {32'd0, clear_mask}, {32'd0, m});
        end
    end

    task automatic set_src(input int i, input logic v, input logic [4:0] r,
                           input logic [63:0] d);
        src_valid[i]        = v;
        src_rd[i*AW +: AW]  = r;
        src_data[i*DW +: DW] = d;
    endtask

    // Record every transfer that will happen at the coming edge.
    task automatic commit();
        ent_t e;
        for (int i = 0; i < 3; i++) begin
            if (src_valid[i] && src_ready[i] && src_rd[i*AW +: AW] != 0) begin
                e.src  = i;
                e.rd   = src_rd[i*AW +: AW];
                e.data = src_data[i*DW +: DW];
                sb_q.push_back(e);
            end
        end
    endtask

    task automatic idle();
        src_valid = 3'b000;
    endtask

    initial begin
        int seq [3];
        int cnt [3];
        bit seen0 [3];
        bit seen1 [3];
        int t;

        for (int i = 0; i < 32; i++) regf[i] = '0;
        rst       = 1'b1;
        src_valid = '0;
        src_rd    = '0;
        src_data  = '0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_we_a", {63'd0, we_a}, 64'd0);
        chk("reset_we_b", {63'd0, we_b}, 64'd0);
        chk("reset_mask", {32'd0, clear_mask}, 64'd0);
        chk("reset_ready", {61'd0, src_ready}, 64'd7);
        rst    = 1'b0;
        mon_en = 1'b1;

        // Single write from ALU.
        @(negedge clk);
        set_src(0, 1'b1, 5'd5, 64'hdeadbeefdeadbeef);
        commit();
        @(negedge clk);
        idle();
        @(negedge clk);
        chk("single_we_a", {63'd0, we_a}, 64'd1);
        chk("single_addr_a", {59'd0, addr_a}, 64'd5);
        chk("single_data_a", data_a, 64'hdeadbeefdeadbeef);
        chk("single_mask", {32'd0, clear_mask}, 64'h20);
        chk("single_we_b", {63'd0, we_b}, 64'd0);

        // Dual issue LSU + NPU.
        @(negedge clk);
        set_src(1, 1'b1, 5'd10, 64'hcafef00dcafef00d);
        set_src(2, 1'b1, 5'd7, 64'h1);
        commit();
        @(negedge clk);
        idle();
        @(negedge clk);
        chk("dual_addr_a", {59'd0, addr_a}, 64'd10);
        chk("dual_data_a", data_a, 64'hcafef00dcafef00d);
        chk("dual_we_b", {63'd0, we_b}, 64'd1);
        chk("dual_addr_b", {59'd0, addr_b}, 64'd7);
        chk("dual_data_b", data_b, 64'h1);
        chk("dual_mask", {32'd0, clear_mask}, 64'h480);

        // Same-rd conflict: ALU first, LSU one cycle later.
        @(negedge clk);
        set_src(0, 1'b1, 5'd3, 64'hA);
        set_src(1, 1'b1, 5'd3, 64'hB);
        commit();
        @(negedge clk);
        idle();
        @(negedge clk);
        chk("conf_n_we_a", {63'd0, we_a}, 64'd1);
        chk("conf_n_addr_a", {59'd0, addr_a}, 64'd3);
        chk("conf_n_data_a", data_a, 64'hA);
        chk("conf_n_we_b", {63'd0, we_b}, 64'd0);
        @(negedge clk);
        chk("conf_n1_we_a", {63'd0, we_a}, 64'd1);
        chk("conf_n1_addr_a", {59'd0, addr_a}, 64'd3);
        chk("conf_n1_data_a", data_a, 64'hB);
        chk("conf_n1_we_b", {63'd0, we_b}, 64'd0);
        @(negedge clk);
        chk("conf_final_x3", regf[3], 64'hB);

        // x0 drop.
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k < 4) begin
                set_src(2, 1'b1, 5'd0, 64'h77);
                commit();
            end else begin
                idle();
            end
            chk("x0_ready2", {63'd0, src_ready[2]}, 64'd1);
            chk("x0_no_we", {62'd0, we_a, we_b}, 64'd0);
        end

        // Reset mid-stream.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            set_src(0, 1'b1, 5'd1, 64'h100 + 64'(k));
            set_src(1, 1'b1, 5'd2, 64'h200 + 64'(k));
            set_src(2, 1'b1, 5'd4, 64'h400 + 64'(k));
            commit();
        end
        @(negedge clk);
        idle();
        rst = 1'b1;
        @(negedge clk);
        sb_q.delete();
        chk("midrst_we_a", {63'd0, we_a}, 64'd0);
        chk("midrst_we_b", {63'd0, we_b}, 64'd0);
        chk("midrst_mask", {32'd0, clear_mask}, 64'd0);
        chk("midrst_ready", {61'd0, src_ready}, 64'd7);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Fairness stream: disjoint rd ranges per producer.
        for (int i = 0; i < 3; i++) begin
            seq[i] = 0;
            cnt[i] = 0;
            seen0[i] = 1'b0;
            seen1[i] = 1'b0;
        end
        for (int k = 0; k < 33; k++) begin
            @(negedge clk);
            if (k >= 2 && k <= 31) begin
                chk("stream_dual", {62'd0, we_a, we_b}, 64'd3);
                if (we_a) begin
                    t = int'(data_a[63:56]) - 1;
                    if (t >= 0 && t < 3) cnt[t]++;
                end
                if (we_b) begin
                    t = int'(data_b[63:56]) - 1;
                    if (t >= 0 && t < 3) cnt[t]++;
                end
                for (int i = 0; i < 3; i++) begin
                    if (src_ready[i]) seen1[i] = 1'b1;
                    else seen0[i] = 1'b1;
                end
            end
            for (int i = 0; i < 3; i++) begin
                set_src(i, 1'b1, 5'(1 + i*10 + (seq[i] % 10)),
                        {8'(i + 1), 56'(seq[i])});
                if (src_ready[i]) seq[i]++;
            end
            commit();
        end
        @(negedge clk);
        idle();
        repeat (6) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("fair_cnt_ok%0d", i),
                {63'd0, cnt[i] >= 19 && cnt[i] <= 21}, 64'd1);
            chk($sformatf("ready_toggle%0d", i),
                {62'd0, seen0[i], seen1[i]}, 64'd3);
        end
        chk("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
